// File: rtl/shapool_pkg.sv
// shapool_pkg: types and helpers shared by the result-collector slice.
// Holds the collector state enum, the core-index width helper and nonce width default.
package shapool_pkg;

  localparam int NONCE_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FOUND,
    ST_EXHAUSTED
  } state_e;

  // Core index needs at least one bit even for a single-core pool.
  function automatic int core_w(input int log2);
    return (log2 < 1) ? 1 : log2;
  endfunction

endpackage

// File: rtl/shapool_result_collector_if.sv
// shapool_result_collector_if: job control, per-core flags/nonces and result pins.
// master = job/core side driving the collector; slave = the collector itself.
interface shapool_result_collector_if
  import shapool_pkg::*;
#(
  parameter int POOL_SIZE   = 4,
  parameter int NONCE_WIDTH = NONCE_WIDTH_DEF,
  parameter int CORE_W      = 2
);

  logic                           start_in;
  logic                           halt_in;
  logic [POOL_SIZE-1:0]           core_success_in;
  logic [POOL_SIZE-1:0]           core_done_in;
  logic [POOL_SIZE*NONCE_WIDTH-1:0] core_nonce_in;
  logic                           result_ack_in;

  logic                   halt_out;
  logic                   result_valid_out;
  logic [NONCE_WIDTH-1:0] result_nonce_out;
  logic [CORE_W-1:0]      result_core_out;
  logic                   ready_n_out;
  logic                   ready_oe_out;
  logic                   status_led_n_out;

  modport master (
    output start_in, halt_in,
    output core_success_in, core_done_in,
    output core_nonce_in, result_ack_in,
    input  halt_out, result_valid_out,
    input  result_nonce_out, result_core_out,
    input  ready_n_out, ready_oe_out,
    input  status_led_n_out
  );

  modport slave (
    input  start_in, halt_in,
    input  core_success_in, core_done_in,
    input  core_nonce_in, result_ack_in,
    output halt_out, result_valid_out,
    output result_nonce_out, result_core_out,
    output ready_n_out, ready_oe_out,
    output status_led_n_out
  );

endinterface

// File: rtl/shapool_rr_arbiter.sv
// shapool_rr_arbiter: combinational round-robin pick among core requests.
// Ports: req (per-core), ptr (first core to consider) -> grant (one-hot), idx, hit.
module shapool_rr_arbiter
  import shapool_pkg::*;
#(
  parameter int POOL_SIZE = 4,
  parameter int CORE_W    = 2
) (
  input  logic [POOL_SIZE-1:0] req,
  input  logic [CORE_W-1:0]    ptr,
  output logic [POOL_SIZE-1:0] grant,
  output logic [CORE_W-1:0]    idx,
  output logic                 hit
);

  logic              hi_hit;
  logic              lo_hit;
  logic [CORE_W-1:0] hi_idx;
  logic [CORE_W-1:0] lo_idx;

  // Scan downwards so the lowest requester in each half wins:
  // "hi" is at/after ptr, "lo" wraps around below ptr.
  always_comb begin
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int k = POOL_SIZE - 1; k >= 0; k--) begin
      if (req[k]) begin
        if (k >= int'(ptr)) begin
          hi_hit = 1'b1;
          hi_idx = CORE_W'(k);
        end else begin
          lo_hit = 1'b1;
          lo_idx = CORE_W'(k);
        end
      end
    end
  end

  assign hit   = hi_hit | lo_hit;
  assign idx   = hi_hit ? hi_idx : lo_idx;
  assign grant = hit ? (POOL_SIZE'(1) << idx) : '0;

endmodule

// File: rtl/shapool_result_collector.sv
// shapool_result_collector: picks one winning core, latches its nonce, drives ready/LED.
// Ports: clk_in, reset_in (sync, active-high), bus (slave side of the collector interface).
// Optional SHAPOOL_NONCE_OFFSET_EN: winner index replaces the nonce MSBs.
module shapool_result_collector
  import shapool_pkg::*;
#(
  parameter int POOL_SIZE      = 4,
  parameter int POOL_SIZE_LOG2 = 2,
  parameter int NONCE_WIDTH    = NONCE_WIDTH_DEF,
  parameter int LED_DIV_LOG2   = 22
) (
  input logic clk_in,
  input logic reset_in,
  shapool_result_collector_if.slave bus
);

  localparam int CORE_W = core_w(POOL_SIZE_LOG2);
  localparam int NW     = NONCE_WIDTH;
  localparam int CNT_W  = LED_DIV_LOG2 + 1;

  state_e            state_q;
  state_e            state_d;
  logic [CORE_W-1:0] ptr_q;
  logic [CORE_W-1:0] ptr_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [NW-1:0]     nonce_q;
  logic [NW-1:0]     nonce_d;
  logic [CORE_W-1:0] core_q;
  logic [CORE_W-1:0] core_d;

  logic [POOL_SIZE-1:0] grant;
  logic [CORE_W-1:0]    win_idx;
  logic                 win_hit;
  logic [NW-1:0]        win_raw;
  logic [NW-1:0]        win_nonce;
  logic                 led_n;

  shapool_rr_arbiter #(
    .POOL_SIZE(POOL_SIZE),
    .CORE_W   (CORE_W)
  ) u_arb (
    .req  (bus.core_success_in),
    .ptr  (ptr_q),
    .grant(grant),
    .idx  (win_idx),
    .hit  (win_hit)
  );

  always_comb begin
    win_raw = '0;
    for (int k = 0; k < POOL_SIZE; k++) begin
      if (grant[k]) begin
        win_raw = win_raw | bus.core_nonce_in[k*NW +: NW];
      end
    end
  end

`ifdef SHAPOOL_NONCE_OFFSET_EN
  if (POOL_SIZE_LOG2 > 0) begin : g_offset
    assign win_nonce = {win_idx[POOL_SIZE_LOG2-1:0],
                        win_raw[NW-POOL_SIZE_LOG2-1:0]};
  end else begin : g_offset_bad
    $error("SHAPOOL_NONCE_OFFSET_EN needs POOL_SIZE_LOG2 > 0");
    assign win_nonce = win_raw;
  end
`else
  assign win_nonce = win_raw;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    nonce_d = nonce_q;
    core_d  = core_q;
    if (state_q == ST_RUN) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (bus.halt_in) begin
      state_d = ST_IDLE;
    end else if (bus.start_in) begin
      // Start beats a same-cycle success; any pending result is dropped.
      state_d = ST_RUN;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (win_hit) begin
            state_d = ST_FOUND;
            nonce_d = win_nonce;
            core_d  = win_idx;
            ptr_d   = (win_idx == CORE_W'(POOL_SIZE - 1))
                      ? '0 : win_idx + 1'b1;
          end else if (&bus.core_done_in) begin
            state_d = ST_EXHAUSTED;
          end
        end
        ST_FOUND: begin
          if (bus.result_ack_in) begin
            state_d = ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      nonce_q <= '0;
      core_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      nonce_q <= nonce_d;
      core_q  <= core_d;
    end
  end

  always_comb begin
    led_n = 1'b1;
    unique case (state_q)
      ST_RUN:   led_n = ~cnt_q[LED_DIV_LOG2];
      ST_FOUND: led_n = 1'b0;
      default:  led_n = 1'b1;
    endcase
  end

  assign bus.halt_out         = (state_q != ST_RUN);
  assign bus.result_valid_out = (state_q == ST_FOUND);
  assign bus.ready_oe_out     = (state_q == ST_FOUND);
  assign bus.ready_n_out      = 1'b0;
  assign bus.result_nonce_out = nonce_q;
  assign bus.result_core_out  = core_q;
  assign bus.status_led_n_out = led_n;

endmodule

// File: tb/tb_shapool_result_collector.sv
// tb_shapool_result_collector: scoreboard bench for a 4-core and a 1-core collector.
// Directed scenarios then randomized traffic, checked against a per-cycle reference model.
module tb_shapool_result_collector;

  localparam int NW = 32;
  localparam int L4 = 4;
  localparam int L1 = 3;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_FND  = 2;
  localparam int M_EXH  = 3;

  typedef struct packed {
    logic        halt;
    logic        valid;
    logic        oe;
    logic        rn;
    logic        led;
    logic [1:0]  core;
    logic [31:0] nonce;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rs[2];
  logic          st[2];
  logic          hl[2];
  logic          ak[2];
  logic [3:0]    sc[2];
  logic [3:0]    dn[2];
  logic [NW-1:0] nz[2][4];

  int          m_mode[2];
  int          m_ptr[2];
  int          m_age[2];
  int          m_core[2];
  logic [31:0] m_nonce[2];
  int          psz[2]  = '{4, 1};
  int          plog[2] = '{2, 0};
  int          ldiv[2] = '{L4, L1};

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1, a0, a1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mcyc     = 0;

  shapool_result_collector_if #(
    .POOL_SIZE(4), .NONCE_WIDTH(NW), .CORE_W(2)
  ) i4 ();
  shapool_result_collector_if #(
    .POOL_SIZE(1), .NONCE_WIDTH(NW), .CORE_W(1)
  ) i1 ();

  assign i4.start_in        = st[0];
  assign i4.halt_in         = hl[0];
  assign i4.result_ack_in   = ak[0];
  assign i4.core_success_in = sc[0];
  assign i4.core_done_in    = dn[0];
  assign i4.core_nonce_in   = {nz[0][3], nz[0][2], nz[0][1], nz[0][0]};
  assign i1.start_in        = st[1];
  assign i1.halt_in         = hl[1];
  assign i1.result_ack_in   = ak[1];
  assign i1.core_success_in = sc[1][0];
  assign i1.core_done_in    = dn[1][0];
  assign i1.core_nonce_in   = nz[1][0];

  shapool_result_collector #(
    .POOL_SIZE(4), .POOL_SIZE_LOG2(2),
    .NONCE_WIDTH(NW), .LED_DIV_LOG2(L4)
  ) dut4 (
    .clk_in(clk), .reset_in(rs[0]), .bus(i4)
  );

`ifndef SHAPOOL_NONCE_OFFSET_EN
  shapool_result_collector #(
    .POOL_SIZE(1), .POOL_SIZE_LOG2(0),
    .NONCE_WIDTH(NW), .LED_DIV_LOG2(L1)
  ) dut1 (
    .clk_in(clk), .reset_in(rs[1]), .bus(i1)
  );
`endif

  function automatic logic [31:0] pick(input int d, input int w);
    logic [31:0] raw;
    raw = nz[d][w];
`ifdef SHAPOOL_NONCE_OFFSET_EN
    begin
      int sh;
      sh = 32 - plog[d];
      return (32'(w) << sh) | (raw & ((32'h1 << sh) - 32'h1));
    end
`else
    return raw;
`endif
  endfunction

  task automatic model_step(input int d);
    int w;
    int c;
    logic alld;
    if (rs[d]) begin
      m_mode[d] = M_IDLE; m_ptr[d] = 0; m_age[d] = 0;
      m_core[d] = 0; m_nonce[d] = '0;
    end else if (hl[d]) begin
      m_mode[d] = M_IDLE;
    end else if (st[d]) begin
      m_mode[d] = M_RUN; m_age[d] = 0;
    end else if (m_mode[d] == M_RUN) begin
      m_age[d]++;
      w = -1;
      alld = 1'b1;
      for (int i = 0; i < psz[d]; i++) begin
        c = (m_ptr[d] + i) % psz[d];
        if (w < 0 && sc[d][c]) w = c;
        alld = alld & dn[d][i];
      end
      if (w >= 0) begin
        m_mode[d]  = M_FND;
        m_core[d]  = w;
        m_nonce[d] = pick(d, w);
        m_ptr[d]   = (w + 1) % psz[d];
      end else if (alld) begin
        m_mode[d] = M_EXH;
      end
    end else if (m_mode[d] == M_FND && ak[d]) begin
      m_mode[d] = M_IDLE;
    end
  endtask

  function automatic exp_t model_out(input int d);
    exp_t e;
    e.halt  = (m_mode[d] != M_RUN);
    e.valid = (m_mode[d] == M_FND);
    e.oe    = (m_mode[d] == M_FND);
    e.rn    = 1'b0;
    if (m_mode[d] == M_RUN)
      e.led = (((m_age[d] >> ldiv[d]) & 1) == 0);
    else
      e.led = (m_mode[d] != M_FND);
    e.core  = 2'(m_core[d]);
    e.nonce = m_nonce[d];
    return e;
  endfunction

  task automatic tick();
    model_step(0);
    q0.push_back(model_out(0));
    model_step(1);
`ifndef SHAPOOL_NONCE_OFFSET_EN
    q1.push_back(model_out(1));
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input exp_t a, input exp_t e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got h=%b v=%b oe=%b rn=%b led=%b core=%0d nonce=%h want h=%b v=%b oe=%b rn=%b led=%b core=%0d nonce=%h",
               nm, mcyc, a.halt, a.valid, a.oe, a.rn, a.led, a.core, a.nonce,
               e.halt, e.valid, e.oe, e.rn, e.led, e.core, e.nonce);
    end
  endtask

  // Monitor: each edge retires one expected snapshot per DUT.
  initial begin
    forever begin
      @(posedge clk);
      if (q0.size() > 0) begin
        e0 = q0.pop_front();
`ifndef SHAPOOL_NONCE_OFFSET_EN
        e1 = q1.pop_front();
`endif
        @(negedge clk);
        mcyc++;
        a0 = {i4.halt_out, i4.result_valid_out, i4.ready_oe_out,
              i4.ready_n_out, i4.status_led_n_out,
              i4.result_core_out, i4.result_nonce_out};
        check("pool4_outputs", a0, e0);
`ifndef SHAPOOL_NONCE_OFFSET_EN
        a1 = {i1.halt_out, i1.result_valid_out, i1.ready_oe_out,
              i1.ready_n_out, i1.status_led_n_out,
              {1'b0, i1.result_core_out}, i1.result_nonce_out};
        check("pool1_outputs", a1, e1);
`endif
      end
    end
  end

  task automatic clr_pulses();
    for (int d = 0; d < 2; d++) begin
      rs[d] = 1'b0; st[d] = 1'b0; hl[d] = 1'b0; ak[d] = 1'b0;
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      sc[d] = '0; dn[d] = '0;
      for (int i = 0; i < 4; i++) nz[d][i] = $urandom;
    end
    clr_pulses();
    rs[0] = 1'b1; rs[1] = 1'b1;
    tick(); tick();
    clr_pulses(); tick();
    // start both; pool4: core2 wins with 0x1234
    st[0] = 1'b1; st[1] = 1'b1; tick(); clr_pulses();
    nz[0][2] = 32'h0000_1234; sc[0] = 4'b0100; tick(); sc[0] = '0;
    repeat (3) tick();
    ak[0] = 1'b1; tick(); clr_pulses();
    // simultaneous cores 1 and 3 from ptr 0, then again from ptr 2
    rs[0] = 1'b1; tick(); clr_pulses();
    st[0] = 1'b1; tick(); clr_pulses();
    sc[0] = 4'b1010; tick(); sc[0] = '0; tick();
    ak[0] = 1'b1; tick(); clr_pulses();
    st[0] = 1'b1; tick(); clr_pulses();
    sc[0] = 4'b1010; tick(); sc[0] = '0; tick();
    ak[0] = 1'b1; tick(); clr_pulses();
    // pool1 has been running through LED toggles; now it finds
    repeat (4) tick();
    nz[1][0] = 32'hDEAD_BEEF; sc[1] = 4'b0001; tick(); sc[1] = '0;
    tick(); ak[1] = 1'b1; tick(); clr_pulses();
    // exhaustion then restart
    st[0] = 1'b1; tick(); clr_pulses();
    dn[0] = 4'hF; repeat (3) tick();
    st[0] = 1'b1; dn[0] = '0; tick(); clr_pulses(); tick();
    // found then halt; late ack ignored
    sc[0] = 4'b0001; tick(); sc[0] = '0; tick();
    hl[0] = 1'b1; tick(); clr_pulses();
    ak[0] = 1'b1; tick(); clr_pulses(); tick();
    // reset mid-run with success pending
    st[0] = 1'b1; tick(); clr_pulses(); repeat (3) tick();
    rs[0] = 1'b1; sc[0] = 4'b0100; tick(); clr_pulses();
    sc[0] = '0; repeat (2) tick();
    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      for (int d = 0; d < 2; d++) begin
        rs[d] = ($urandom_range(0, 499) == 0);
        hl[d] = ($urandom_range(0, 59) == 0);
        st[d] = (m_mode[d] != M_RUN) && ($urandom_range(0, 7) == 0);
        ak[d] = ($urandom_range(0, 5) == 0);
        for (int i = 0; i < 4; i++) begin
          sc[d][i] = ($urandom_range(0, 24) == 0);
          nz[d][i] = $urandom;
        end
        dn[d] = ($urandom_range(0, 19) == 0) ? 4'hF : 4'($urandom);
      end
      tick();
    end
    clr_pulses();
    sc[0] = '0; sc[1] = '0; dn[0] = '0; dn[1] = '0;
    repeat (3) tick();
    @(negedge clk);
    #1;
    n_checks++;
    if (q0.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d snapshots left, want 0", q0.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
